// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU-side and response signals shared between the arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the requesters/ALU/consumer view.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [2:0]             req0_aluop;
  logic [5:0]             req0_funct;
  logic [DATA_WIDTH-1:0]  req0_a;
  logic [DATA_WIDTH-1:0]  req0_b;
  logic [SHAMT_WIDTH-1:0] req0_shamt;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [2:0]             req1_aluop;
  logic [5:0]             req1_funct;
  logic [DATA_WIDTH-1:0]  req1_a;
  logic [DATA_WIDTH-1:0]  req1_b;
  logic [SHAMT_WIDTH-1:0] req1_shamt;

  logic [2:0]             alu_aluop_o;
  logic [5:0]             alu_funct_o;
  logic [DATA_WIDTH-1:0]  alu_a_o;
  logic [DATA_WIDTH-1:0]  alu_b_o;
  logic [SHAMT_WIDTH-1:0] alu_shamt_o;
  logic [3:0]             alu_operation_i;
  logic [DATA_WIDTH-1:0]  alu_result_i;
  logic                   alu_zero_i;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [DATA_WIDTH-1:0]  rsp_result;
  logic                   rsp_zero;
  logic                   rsp_err;

  modport slave (
    input  req0_valid, req0_aluop, req0_funct, req0_a, req0_b, req0_shamt,
    input  req1_valid, req1_aluop, req1_funct, req1_a, req1_b, req1_shamt,
    output req0_ready, req1_ready,
    output alu_aluop_o, alu_funct_o, alu_a_o, alu_b_o, alu_shamt_o,
    input  alu_operation_i, alu_result_i, alu_zero_i,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_aluop, req0_funct, req0_a, req0_b, req0_shamt,
    output req1_valid, req1_aluop, req1_funct, req1_a, req1_b, req1_shamt,
    input  req0_ready, req1_ready,
    input  alu_aluop_o, alu_funct_o, alu_a_o, alu_b_o, alu_shamt_o,
    output alu_operation_i, alu_result_i, alu_zero_i,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALUControl+ALU pair between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ERR_CHECK_EN to flag ALUOperation 4'b1001 as unsupported (rsp_err, zeroed result).
module alu_share_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   last_q;
  logic                   grant;
  logic                   accept;
  logic                   rsp_hs;
  logic [2:0]             aluop_q;
  logic [5:0]             funct_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q;
  logic [SHAMT_WIDTH-1:0] shamt_q;
  logic                   id_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic                   zero_q;

  // A lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_q;
  end

  assign accept = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant;
    bus.req1_ready = (state_q == IDLE) && bus.req1_valid && grant;
    bus.rsp_valid  = (state_q == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q   <= 1'b1;
      aluop_q  <= '0;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        aluop_q <= grant ? bus.req1_aluop : bus.req0_aluop;
        funct_q <= grant ? bus.req1_funct : bus.req0_funct;
        a_q     <= grant ? bus.req1_a     : bus.req0_a;
        b_q     <= grant ? bus.req1_b     : bus.req0_b;
        shamt_q <= grant ? bus.req1_shamt : bus.req0_shamt;
        id_q    <= grant;
      end
      if (state_q == EXEC) begin
`ifdef ALU_ARB_ERR_CHECK_EN
        result_q <= (bus.alu_operation_i == 4'b1001) ? '0 : bus.alu_result_i;
        zero_q   <= (bus.alu_operation_i == 4'b1001) ? 1'b0 : bus.alu_zero_i;
`else
        result_q <= bus.alu_result_i;
        zero_q   <= bus.alu_zero_i;
`endif
      end
      if (rsp_hs) last_q <= id_q;
    end
  end

`ifdef ALU_ARB_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset)                err_q <= 1'b0;
    else if (state_q == EXEC)  err_q <= (bus.alu_operation_i == 4'b1001);
  end

  assign bus.rsp_err = err_q;
`else
  logic unused_op;

  assign unused_op   = ^bus.alu_operation_i;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.alu_aluop_o = aluop_q;
  assign bus.alu_funct_o = funct_q;
  assign bus.alu_a_o     = a_q;
  assign bus.alu_b_o     = b_q;
  assign bus.alu_shamt_o = shamt_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;

endmodule
